// File: rtl/toggle_pulse_gen_if.sv
// Button-to-toggle-pulse signal bundle.
// The bench or button side uses master; toggle_pulse_gen uses slave.
interface toggle_pulse_gen_if;
    logic       btn_in;
    logic       t;
    logic       btn_level;
    logic [7:0] press_count;

    modport master (
        output btn_in,
        input  t,
        input  btn_level,
        input  press_count
    );

    modport slave (
        input  btn_in,
        output t,
        output btn_level,
        output press_count
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Debounced single-pulse generator feeding a T flip-flop.
// A raw button is synchronised, then debounced by a counter FSM.
// Each accepted press produces exactly one registered one-cycle t pulse.
module toggle_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    toggle_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic                 s1_q, s2_q;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 t_q, t_d;
    logic                 level_q, level_d;
    logic [7:0]           count_q, count_d;

    // Polarity-normalised two-flop synchroniser plus all FSM state; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            s1_q    <= bus.btn_in ^ BTN_ACTIVE_LOW;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    // Debounce FSM: any bounce restarts the stable window from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = 1'b0;
        level_d = level_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (s2_q) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!s2_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    t_d     = 1'b1;
                    level_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPressed: begin
                if (!s2_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                // A bounce back to pressed keeps the level high and never re-pulses.
                if (s2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.t           = t_q;
    assign bus.btn_level   = level_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen with DEBOUNCE_CYCLES=4.
module tb_toggle_pulse_gen;

    localparam int D = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    toggle_pulse_gen_if bus ();

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (16),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run-length model: the debounced level flips once the synchronised input
    // has disagreed with it on D+1 consecutive edges (first sample enters the
    // wait state, D more complete the window), i.e. D+2 cycles after btn_in.
    logic       m_h1, m_h2, m_level, m_t;
    int         m_run;
    logic [7:0] m_count;

    always @(posedge clk) begin
        if (rst) begin
            m_h1 = 0; m_h2 = 0; m_level = 0; m_t = 0; m_run = 0; m_count = 0;
        end else begin
            m_t = 0;
            if (m_h2 != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = m_h2;
                    m_run   = 0;
                    if (m_h2) begin
                        m_t = 1;
                        m_count = m_count + 8'd1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_h2 = m_h1;
            m_h1 = bus.btn_in;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_t", 32'(bus.t), 32'(m_t));
            check("model_level", 32'(bus.btn_level), 32'(m_level));
            check("model_count", 32'(bus.press_count), 32'(m_count));
        end
    end

    // Drives pat[0..len-1] one bit per cycle (then holds the last bit) for total
    // cycles; reports iteration of first t pulse, pulse count, first level change.
    task automatic run_seq(input logic [15:0] pat, input int len, input int total,
                           output int first_t, output int n_t, output int first_lvl);
        logic start_lvl;
        start_lvl = bus.btn_level;
        first_t   = -1;
        n_t       = 0;
        first_lvl = -1;
        for (int i = 0; i < total; i++) begin
            bus.btn_in = (i < len) ? pat[i] : pat[len-1];
            @(negedge clk);
            if (bus.t === 1'b1) begin
                if (n_t == 0) first_t = i;
                n_t++;
            end
            if (first_lvl < 0 && bus.btn_level !== start_lvl) first_lvl = i;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.btn_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ft, nt, fl, total;
        rst        = 1'b1;
        bus.btn_in = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        // Reset values with button held.
        for (int i = 0; i < 3; i++) begin
            check("rst_t", 32'(bus.t), 32'd0);
            check("rst_level", 32'(bus.btn_level), 32'd0);
            check("rst_count", 32'(bus.press_count), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        run_seq(16'h1, 1, 15, ft, nt, fl);
        check("post_rst_first_t", ft, 6);
        check("post_rst_n_t", nt, 1);
        run_seq(16'h0, 1, 12, ft, nt, fl);
        check("post_rst_count", 32'(bus.press_count), 32'd1);

        // Clean press and release.
        run_seq(16'h1, 1, 20, ft, nt, fl);
        check("clean_first_t", ft, 6);
        check("clean_n_t", nt, 1);
        check("clean_lvl_at", fl, 6);
        check("clean_count", 32'(bus.press_count), 32'd2);
        run_seq(16'h0, 1, 20, ft, nt, fl);
        check("release_n_t", nt, 0);
        check("release_lvl_at", fl, 6);

        // Bouncy press: last 0->1 at index 5.
        run_seq(16'h03ED, 10, 20, ft, nt, fl);
        check("bouncy_first_t", ft, 11);
        check("bouncy_n_t", nt, 1);
        check("bouncy_count", 32'(bus.press_count), 32'd3);
        run_seq(16'h0, 1, 12, ft, nt, fl);

        // Short glitches while idle.
        run_seq(16'h1, 2, 12, ft, nt, fl);
        check("glitch1_n_t", nt, 0);
        check("glitch1_lvl", fl, -1);
        run_seq(16'h3, 3, 12, ft, nt, fl);
        check("glitch2_n_t", nt, 0);
        check("glitch2_lvl", fl, -1);
        run_seq(16'h7, 4, 12, ft, nt, fl);
        check("glitch3_n_t", nt, 0);
        check("glitch3_lvl", fl, -1);

        // Release bounce while pressed.
        run_seq(16'h1, 1, 10, ft, nt, fl);
        check("press4_first_t", ft, 6);
        run_seq(16'hA, 4, 20, ft, nt, fl);
        check("rel_bounce_n_t", nt, 0);
        check("rel_bounce_lvl", fl, -1);
        check("rel_bounce_count", 32'(bus.press_count), 32'd4);
        run_seq(16'h0, 1, 10, ft, nt, fl);
        check("rel_bounce_release_at", fl, 6);

        // Counter wrap over 256 presses.
        do_reset();
        total = 0;
        for (int k = 0; k < 256; k++) begin
            run_seq(16'h1, 1, 8, ft, nt, fl);
            total += nt;
            if (k == 254) check("wrap_count_255", 32'(bus.press_count), 32'd255);
            run_seq(16'h0, 1, 8, ft, nt, fl);
            total += nt;
        end
        check("wrap_pulses", total, 256);
        check("wrap_count_end", 32'(bus.press_count), 32'd0);

        // Reset mid-window at cnt=2 with button held.
        do_reset();
        run_seq(16'h1, 1, 5, ft, nt, fl);
        check("midwin_pre_n_t", nt, 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midwin_rst_t", 32'(bus.t), 32'd0);
        end
        rst = 1'b0;
        run_seq(16'h1, 1, 12, ft, nt, fl);
        check("midwin_first_t", ft, 6);
        check("midwin_n_t", nt, 1);
        check("midwin_count", 32'(bus.press_count), 32'd1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
